// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified instruction/data SRAM arbiter.
//   owner_t        : which requester owns the read data returning next cycle
//   DEFAULT_ADDR_W : default SRAM word-address width (2048 words)
//   addr_ok()      : byte address is word aligned and inside the SRAM
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned DEFAULT_ADDR_W = 11;
  // Width the address check operates on; callers zero-extend into it.
  localparam int unsigned CHK_W          = 64;

  // Good when the low two bits are zero and nothing is set above the word index.
  function automatic logic addr_ok(input logic [CHK_W-1:0] addr,
                                   input int unsigned      addr_w);
    logic [CHK_W-1:0] w_hi;
    w_hi = addr >> (addr_w + 2);
    return (addr[1:0] == 2'b00) && (w_hi == '0);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between the fetch port and the data port.
// Data wins by default; a starvation counter forces a fetch grant after
// MAX_STARVE consecutive data grants while fetch waits. Read data returns
// one cycle after the grant, steered to its owner and held afterwards.
// Ports:
//   clk, rst                          clock, async active-high reset
//   if_req/if_addr                    fetch read request
//   if_gnt/if_err/if_rvalid/if_rdata  fetch grant, bad-address flag, return
//   d_req/d_we/d_addr/d_wdata         data request
//   d_gnt/d_err/d_rvalid/d_rdata      data grant, bad-address flag, return
//   mem_cen/mem_wen/mem_a/mem_d/mem_q SRAM macro interface (active-low enables)
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WIDTH-1:0]  if_addr,
  output logic              if_gnt,
  output logic              if_err,
  output logic              if_rvalid,
  output logic [WIDTH-1:0]  if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WIDTH-1:0]  d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_err,
  output logic              d_rvalid,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [WIDTH-1:0]  mem_d,
  input  logic [WIDTH-1:0]  mem_q
);

  localparam int unsigned      CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

  logic [CNT_W-1:0]  r_starve;
  logic [CNT_W-1:0]  w_starve_nxt;
  owner_t            r_owner;
  owner_t            w_owner_nxt;
  logic [WIDTH-1:0]  r_if_hold;
  logic [WIDTH-1:0]  r_d_hold;
  logic              w_if_ok;
  logic              w_d_ok;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic [ADDR_W-1:0] w_if_idx;
  logic [ADDR_W-1:0] w_d_idx;

  assign w_if_ok  = addr_ok(CHK_W'(if_addr), ADDR_W);
  assign w_d_ok   = addr_ok(CHK_W'(d_addr), ADDR_W);
  assign w_if_idx = if_addr[ADDR_W+1:2];
  assign w_d_idx  = d_addr[ADDR_W+1:2];

  // Arbitration: data first unless fetch has waited MAX_STARVE grants; nothing in reset.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && (!d_req || (r_starve == STARVE_MAX))) begin
        w_if_gnt = 1'b1;
      end else if (d_req) begin
        w_d_gnt = 1'b1;
      end
    end
  end

  // SRAM controls and owner of next cycle's read data; bad-address grants stay off the SRAM.
  always_comb begin
    mem_cen     = 1'b1;
    mem_wen     = 1'b1;
    mem_a       = '0;
    w_owner_nxt = OWN_NONE;
    if (w_if_gnt && w_if_ok) begin
      mem_cen     = 1'b0;
      mem_a       = w_if_idx;
      w_owner_nxt = OWN_IF;
    end else if (w_d_gnt && w_d_ok) begin
      mem_cen     = 1'b0;
      mem_a       = w_d_idx;
      mem_wen     = ~d_we;
      w_owner_nxt = d_we ? OWN_NONE : OWN_D;
    end
  end

  // Starvation count: grows while data beats a waiting fetch, saturating at the limit.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_if_gnt || !if_req) begin
      w_starve_nxt = '0;
    end else if (w_d_gnt && (r_starve != STARVE_MAX)) begin
      w_starve_nxt = r_starve + CNT_W'(1);
    end
  end

  // State: counter, read owner and the per-port hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve  <= '0;
      r_owner   <= OWN_NONE;
      r_if_hold <= '0;
      r_d_hold  <= '0;
    end else begin
      r_starve <= w_starve_nxt;
      r_owner  <= w_owner_nxt;
      if (r_owner == OWN_IF) r_if_hold <= mem_q;
      if (r_owner == OWN_D)  r_d_hold  <= mem_q;
    end
  end

  assign mem_d     = d_wdata;
  assign if_gnt    = w_if_gnt;
  assign if_err    = w_if_gnt & ~w_if_ok;
  assign d_gnt     = w_d_gnt;
  assign d_err     = w_d_gnt & ~w_d_ok;
  assign if_rvalid = (r_owner == OWN_IF);
  assign d_rvalid  = (r_owner == OWN_D);
  // Returning data passes straight through from the SRAM; otherwise show the last value.
  assign if_rdata  = if_rvalid ? mem_q : r_if_hold;
  assign d_rdata   = d_rvalid ? mem_q : r_d_hold;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: behavioural SRAM, a
// transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_unified_mem_arbiter;

  localparam int unsigned MAXS  = 4;
  localparam int unsigned WORDS = 2048;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_err;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_err;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_cen;
  logic        mem_wen;
  logic [10:0] mem_a;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  int n_chk  = 0;
  int n_fail = 0;

  unified_mem_arbiter #(.WIDTH(32), .ADDR_W(11), .MAX_STARVE(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_err(if_err),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_err(d_err), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up content of the SRAM; word 4 carries the known fetch pattern.
  function automatic logic [31:0] init_word(input int idx);
    logic [31:0] v;
    if (idx == 4) return 32'hDEADBEEF;
    v = 32'(idx) * 32'h9E3779B1;
    return v ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural single-port SRAM, read data one cycle after the access.
  logic [31:0] sram    [WORDS];
  bit          sram_wr [WORDS];
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) begin
        sram[mem_a]    <= mem_d;
        sram_wr[mem_a] <= 1'b1;
      end else begin
        mem_q <= sram_wr[mem_a] ? sram[mem_a] : init_word(int'(mem_a));
      end
    end
  end

  // ---------------- reference model ----------------
  int          m_starve;
  int          m_pend;        // 0 nothing returning, 1 fetch, 2 data
  logic [31:0] m_pdata;
  logic [31:0] m_hold_if;
  logic [31:0] m_hold_d;
  logic [31:0] m_mem [WORDS];
  bit          m_wr  [WORDS];
  bit          last_if_g;
  bit          last_d_g;

  function automatic bit good(input logic [31:0] a);
    return ((a % 4) == 0) && (a < 32'(4 * WORDS));
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    return m_wr[idx] ? m_mem[idx] : init_word(idx);
  endfunction

  function automatic bit exp_if_gnt();
    return !rst && if_req && (!d_req || (m_starve == int'(MAXS)));
  endfunction

  function automatic bit exp_d_gnt();
    return !rst && d_req && !exp_if_gnt();
  endfunction

  task automatic model_reset();
    m_starve  = 0;
    m_pend    = 0;
    m_pdata   = '0;
    m_hold_if = '0;
    m_hold_d  = '0;
    last_if_g = 1'b0;
    last_d_g  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    bit          g_if;
    bit          g_d;
    logic [31:0] e_cen;
    logic [31:0] e_wen;
    logic [31:0] e_a;
    g_if  = exp_if_gnt();
    g_d   = exp_d_gnt();
    e_cen = 1;
    e_wen = 1;
    e_a   = 0;
    if (g_if && good(if_addr)) begin
      e_cen = 0;
      e_a   = if_addr / 4;
    end else if (g_d && good(d_addr)) begin
      e_cen = 0;
      e_a   = d_addr / 4;
      e_wen = d_we ? 0 : 1;
    end
    chk("if_gnt", 32'(if_gnt), 32'(g_if));
    chk("d_gnt", 32'(d_gnt), 32'(g_d));
    chk("if_err", 32'(if_err), 32'(g_if && !good(if_addr)));
    chk("d_err", 32'(d_err), 32'(g_d && !good(d_addr)));
    chk("mem_cen", 32'(mem_cen), e_cen);
    chk("mem_wen", 32'(mem_wen), e_wen);
    chk("mem_a", 32'(mem_a), e_a);
    chk("mem_d", mem_d, d_wdata);
    chk("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
    chk("d_rvalid", 32'(d_rvalid), 32'(m_pend == 2));
    chk("if_rdata", if_rdata, (m_pend == 1) ? m_pdata : m_hold_if);
    chk("d_rdata", d_rdata, (m_pend == 2) ? m_pdata : m_hold_d);
  endtask

  // Advance the model over one clock edge using the inputs of the cycle just ended.
  task automatic model_update();
    bit g_if;
    bit g_d;
    int idx;
    if (rst) begin
      model_reset();
    end else begin
      g_if = exp_if_gnt();
      g_d  = exp_d_gnt();
      if (m_pend == 1) m_hold_if = m_pdata;
      if (m_pend == 2) m_hold_d  = m_pdata;
      m_pend = 0;
      if (g_if && good(if_addr)) begin
        m_pend  = 1;
        m_pdata = m_read(int'(if_addr / 4));
      end else if (g_d && good(d_addr)) begin
        idx = int'(d_addr / 4);
        if (d_we) begin
          m_mem[idx] = d_wdata;
          m_wr[idx]  = 1'b1;
        end else begin
          m_pend  = 2;
          m_pdata = m_read(idx);
        end
      end
      if (g_if || !if_req)      m_starve = 0;
      else if (g_d)             m_starve = (m_starve + 1 > int'(MAXS)) ? int'(MAXS) : m_starve + 1;
      last_if_g = g_if;
      last_d_g  = g_d;
    end
  endtask

  // Check at the falling edge; literal checks may follow before post().
  task automatic pre();
    @(negedge clk);
    model_compare();
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    pre();
    post();
  endtask

  task automatic idle();
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
    if (r == 1) return 32'h2000 + 32'($urandom_range(0, 255)) * 4;
    if (r == 2) return 32'h1FFC;
    return 32'($urandom_range(0, 31)) * 4;
  endfunction

  initial begin
    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    if_req = 1'b1;
    d_req  = 1'b1;
    pre();
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_mem_cen", 32'(mem_cen), 1);
    post();
    cyc();
    idle();
    rst = 1'b0;

    // Fetch of word 4.
    if_req  = 1'b1;
    if_addr = 32'h10;
    pre();
    chk("fetch_gnt", 32'(if_gnt), 1);
    chk("fetch_mem_a", 32'(mem_a), 4);
    chk("fetch_cen", 32'(mem_cen), 0);
    post();
    idle();
    pre();
    chk("fetch_rvalid", 32'(if_rvalid), 1);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    post();
    pre();
    chk("fetch_hold", if_rdata, 32'hDEADBEEF);
    post();

    // Write then read back word 8.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'h12345678;
    pre();
    chk("wr_wen", 32'(mem_wen), 0);
    chk("wr_mem_a", 32'(mem_a), 8);
    post();
    d_we    = 1'b0;
    d_wdata = 32'h0;
    pre();
    chk("wr_no_rvalid", 32'(d_rvalid), 0);
    post();
    idle();
    pre();
    chk("rd_rvalid", 32'(d_rvalid), 1);
    chk("rd_rdata", d_rdata, 32'h12345678);
    post();

    // Misaligned and out-of-range data addresses.
    d_req  = 1'b1;
    d_addr = 32'h22;
    pre();
    chk("mis_gnt", 32'(d_gnt), 1);
    chk("mis_err", 32'(d_err), 1);
    chk("mis_cen", 32'(mem_cen), 1);
    post();
    d_addr = 32'h2000;
    pre();
    chk("oor_gnt", 32'(d_gnt), 1);
    chk("oor_err", 32'(d_err), 1);
    chk("oor_cen", 32'(mem_cen), 1);
    post();
    idle();
    pre();
    chk("bad_no_rvalid", 32'(d_rvalid), 0);
    post();

    // Starvation: four data grants, then fetch, then data again.
    if_req  = 1'b1;
    if_addr = 32'h0;
    d_req   = 1'b1;
    d_addr  = 32'h40;
    for (int k = 0; k < 6; k++) begin
      pre();
      chk("starve_if_gnt", 32'(if_gnt), 32'(k == 4));
      chk("starve_d_gnt", 32'(d_gnt), 32'(k != 4));
      if (k >= 1 && k <= 4) chk("starve_d_rvalid", 32'(d_rvalid), 1);
      if (k == 5)           chk("starve_if_rvalid", 32'(if_rvalid), 1);
      post();
    end
    idle();
    cyc();
    cyc();

    // Reset while a fetch is in flight.
    if_req  = 1'b1;
    if_addr = 32'h10;
    cyc();
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_if_rdata", if_rdata, 0);
    if_req = 1'b1;
    cyc();
    rst = 1'b0;
    pre();
    chk("post_rst_gnt", 32'(if_gnt), 1);
    post();
    idle();
    pre();
    chk("post_rst_rdata", if_rdata, 32'hDEADBEEF);
    post();

    // Randomized traffic; requesters hold until granted, occasionally giving up.
    for (int c = 0; c < 600; c++) begin
      if (!if_req || last_if_g) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = rand_addr();
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req || last_d_g) begin
        d_req   = ($urandom_range(0, 99) < 70);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      cyc();
    end
    idle();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
